// File: rtl/crc_nibble_feeder_pkg.sv
// Shared definitions for the CRC nibble feeder: generator, sequencing lengths, FSM encoding.
package crc_nibble_feeder_pkg;

  localparam logic [3:0] CRC_GEN   = 4'b1001;   // x^3 + 1
  localparam int         NIB_COUNT = 4;
  localparam int         DRAIN_LEN = 2;

  localparam logic [1:0] NIB_LAST   = 2'(NIB_COUNT - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } state_t;

  function automatic logic [3:0] nibble_sel(input logic [15:0] msg, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = msg[15:12];
      2'd1:    nib = msg[11:8];
      2'd2:    nib = msg[7:4];
      default: nib = msg[3:0];
    endcase
    return nib;
  endfunction

  // Under x^3+1 each zero nibble multiplies the remainder by x^4 = x, a left rotate.
  // One drain nibble has reached crc_rem at the capture edge, so rotate back by one.
  function automatic logic [2:0] undo_drain(input logic [2:0] rem);
    return {rem[0], rem[2:1]};
  endfunction

endpackage

// File: rtl/crc_nibble_feeder.sv
// Feeds a 16-bit message MSB nibble first into an external 4-bit/clk x^3+1 CRC stage
// and returns {message, crc} as a codeword with a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a message, CRC stage held clear
// FEED  | presenting message nibbles 0..3
// DRAIN | two zero-nibble cycles while the stage remainder settles
// VALID | codeword presented until downstream accepts
module crc_nibble_feeder
  import crc_nibble_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        crc_clr,
  output logic [3:0]  crc_nib,
  input  logic [2:0]  crc_rem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [18:0] out_code
);

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [15:0] msg;
  logic [2:0]  crc;
  logic        accept, capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      msg   <= '0;
      crc   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept)  msg <= in_data;
      if (capture) crc <= undo_drain(crc_rem);
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    in_ready  = 1'b0;
    crc_clr   = 1'b0;
    crc_nib   = 4'd0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        crc_clr  = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          cnt_nx   = '0;
          state_nx = FEED;
        end
      end
      FEED: begin
        crc_nib = nibble_sel(msg, cnt);
        if (cnt == NIB_LAST) begin
          cnt_nx   = '0;
          state_nx = DRAIN;
        end else begin
          cnt_nx = cnt + 2'd1;
        end
      end
      DRAIN: begin
        // the drain reuses the nibble counter to time its fixed length
        if (cnt == DRAIN_LAST) begin
          capture  = 1'b1;
          cnt_nx   = '0;
          state_nx = VALID;
        end else begin
          cnt_nx = cnt + 2'd1;
        end
      end
      VALID: begin
        out_valid = 1'b1;
        crc_clr   = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_code = {msg, crc};

endmodule
